// File: rtl/mte_receiver.sv
// MAC-then-encrypt receive path: decrypts a framed ciphertext stream, recomputes
// the MAC, and releases the buffered plaintext only when the received tag matches.
module mte_receiver #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 4,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         valid_key,
  output logic         auth_fail,
  output logic [1:0]   state_dbg
);

  // Handshake: a word moves on a port only in a cycle where valid && ready are
  // both high at posedge; the source holds data stable until that happens.

  localparam logic [1:0] RECV    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] TAG_IDX  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [1:0]    state;
  logic [CW-1:0] idx;
  logic [CW-1:0] rd;
  logic [N-1:0]  mac;
  logic [N-1:0]  key_q;
  logic [N-1:0]  tag_q;
  logic [N-1:0]  buf_mem [0:(1<<AW)-1];

  logic          in_fire;
  logic          out_fire;
  logic          first_word;
  logic [N-1:0]  k_cur;
  logic [N-1:0]  m_cur;
  logic [N-1:0]  plain;
  logic [N-1:0]  mac_next;

  assign in_ready  = (state == RECV) && reset_n;
  assign out_valid = (state == RELEASE);
  assign out_last  = (state == RELEASE) && (rd == LAST_IDX);
  assign out_data  = (state == RELEASE) ? buf_mem[rd[AW-1:0]] : '0;
  assign state_dbg = state;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign first_word = (idx == '0);

  // Word 0 uses the live key/seed; key_q is only valid from word 1 on.
  assign k_cur    = first_word ? key : key_q;
  assign m_cur    = first_word ? key : mac;
  assign plain    = in_data ^ k_cur ^ N'(idx);
  assign mac_next = {m_cur[N-2:0], m_cur[N-1]} ^ plain;

  // Plaintext buffer has no reset; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (state == RECV && in_fire && idx != TAG_IDX) begin
      buf_mem[idx[AW-1:0]] <= plain;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= RECV;
      idx       <= '0;
      rd        <= '0;
      mac       <= '0;
      key_q     <= '0;
      tag_q     <= '0;
      valid_key <= 1'b0;
      auth_fail <= 1'b0;
    end else begin
      auth_fail <= 1'b0;
      case (state)
        RECV: begin
          if (in_fire) begin
            if (idx == TAG_IDX) begin
              tag_q <= in_data ^ key_q;
              idx   <= '0;
              state <= CHECK;
            end else begin
              if (first_word) begin
                key_q <= key;
              end
              mac <= mac_next;
              idx <= idx + 1'b1;
            end
          end
        end
        CHECK: begin
          if (mac == tag_q) begin
            valid_key <= 1'b1;
            rd        <= '0;
            state     <= RELEASE;
          end else begin
            valid_key <= 1'b0;
            auth_fail <= 1'b1;
            state     <= RECV;
          end
        end
        RELEASE: begin
          if (out_fire) begin
            if (rd == LAST_IDX) begin
              rd    <= '0;
              state <= RECV;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mte_receiver.sv
// Self-checking bench for mte_receiver: directed scenarios plus randomized frames,
// with expected plaintext produced by a transmit-side encoder model.
module tb_mte_receiver;

  localparam int N  = 8;
  localparam int FL = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         valid_key;
  logic         auth_fail;
  logic [1:0]   state_dbg;

  mte_receiver #(.N(N), .FRAME_LEN(FL)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key       (key),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .valid_key (valid_key),
    .auth_fail (auth_fail),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int fail_seen = 0;
  int exp_fail = 0;
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 manual
  logic [N:0]   exp_q[$];  // {last, data}
  logic         hold_prev = 1'b0;
  logic [N-1:0] prev_data;
  logic         prev_last;

  logic [N-1:0] pt [FL];
  logic [N-1:0] ct [FL+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit-side reference: encrypt pt under k and append the encrypted MAC.
  function automatic void encode(input logic [N-1:0] k);
    logic [N-1:0] m;
    m = k;
    for (int i = 0; i < FL; i++) begin
      ct[i] = pt[i] ^ k ^ N'(i);
      m = {m[N-2:0], m[N-1]} ^ pt[i];
    end
    ct[FL] = m ^ k;
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (auth_fail) fail_seen++;
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        chk("release_in_ready", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("out_data", out_data, exp_q[0][N-1:0]);
          chk("out_last", out_last, exp_q[0][N]);
          if (out_ready) void'(exp_q.pop_front());
        end
        hold_prev = !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // ---------------- driver tasks (all start/end at posedge+1) ----------------
  task automatic idle(input int n);
    if (n > 0) in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [N-1:0] d, input logic [N-1:0] k);
    int n;
    in_data  = d;
    key      = k;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        chk("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] k_first, input logic [N-1:0] k_rest,
                            input int gap_max, input logic good, input logic keep_valid);
    if (good) begin
      for (int i = 0; i < FL; i++) exp_q.push_back({(i == FL - 1), pt[i]});
    end else begin
      exp_fail++;
    end
    for (int i = 0; i <= FL; i++) begin
      idle($urandom_range(0, gap_max));
      send_word(ct[i], (i == 0) ? k_first : k_rest);
    end
    if (!good || !keep_valid) in_valid = 1'b0;
    @(negedge clock);
    chk("check_cycle_out_valid", out_valid, 0);
    chk("check_cycle_in_ready", in_ready, 0);
    chk("check_cycle_auth_fail", auth_fail, 0);
    @(negedge clock);
    if (good) begin
      chk("good_out_valid_t2", out_valid, 1);
      chk("good_auth_fail", auth_fail, 0);
      chk("good_valid_key", valid_key, 1);
    end else begin
      chk("bad_auth_fail_t2", auth_fail, 1);
      chk("bad_in_ready_t2", in_ready, 1);
      chk("bad_out_valid", out_valid, 0);
      chk("bad_valid_key", valid_key, 0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic pulse_reset_and_check(input string tag);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk({tag, "_in_ready_during"}, in_ready, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_valid_key"}, valid_key, 0);
    chk({tag, "_auth_fail"}, auth_fail, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic load_reference();
    pt[0] = 8'h11; pt[1] = 8'h22; pt[2] = 8'h33; pt[3] = 8'h44;
    ct[0] = 8'h4B; ct[1] = 8'h79; ct[2] = 8'h6B; ct[3] = 8'h1D; ct[4] = 8'hDD;
  endtask

  task automatic random_pt();
    for (int i = 0; i < FL; i++) pt[i] = N'($urandom_range(0, 255));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] kf;
    logic         good;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_valid_key", valid_key, 0);
    chk("rst_auth_fail", auth_fail, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Good reference frame
    ready_mode = 0;
    load_reference();
    send_frame(8'h5A, 8'h5A, 0, 1'b1, 1'b0);
    wait_drain();

    // Corrupted tag, then the good frame again
    ct[4] = 8'hDC;
    send_frame(8'h5A, 8'h5A, 0, 1'b0, 1'b0);
    wait_drain();
    ct[4] = 8'hDD;
    send_frame(8'h5A, 8'h5A, 0, 1'b1, 1'b0);
    wait_drain();

    // Input gaps with out_ready toggling every cycle
    ready_mode = 1;
    send_frame(8'h5A, 8'h5A, 3, 1'b1, 1'b0);
    wait_drain();
    ready_mode = 0;

    // Key changes after word 0 must be ignored
    send_frame(8'h5A, 8'h00, 0, 1'b1, 1'b0);
    wait_drain();

    // Reset after two words of a frame
    send_word(ct[0], 8'h5A);
    send_word(ct[1], 8'h5A);
    pulse_reset_and_check("rst_mid_recv");

    // Reset after one released word
    ready_mode = 3;
    out_ready  = 1'b0;
    send_frame(8'h5A, 8'h5A, 0, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("one_word_released", exp_q.size(), FL - 1);
    pulse_reset_and_check("rst_mid_release");
    ready_mode = 0;
    random_pt();
    encode(8'h5A);
    send_frame(8'h5A, 8'h5A, 0, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back frames with in_valid held high
    random_pt();
    encode(8'hC3);
    send_frame(8'hC3, 8'hC3, 0, 1'b1, 1'b1);
    random_pt();
    encode(8'h3C);
    send_frame(8'h3C, 8'h3C, 0, 1'b1, 1'b0);
    wait_drain();

    // Randomized frames, keys, gaps, tag corruption and backpressure
    ready_mode = 2;
    for (int f = 0; f < 10; f++) begin
      random_pt();
      kf = N'($urandom_range(0, 255));
      encode(kf);
      good = ($urandom_range(0, 3) != 0);
      if (!good) ct[FL] = ct[FL] ^ N'($urandom_range(1, 255));
      send_frame(kf, N'($urandom_range(0, 255)), 3, good, 1'b0);
    end
    wait_drain();
    ready_mode = 0;

    idle(5);
    chk("auth_fail_pulses", fail_seen, exp_fail);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mte_receiver.md
Name: mte_receiver

Overview:
- Receive-side counterpart of the MAC-then-encrypt transmit path: accepts a framed ciphertext byte stream, decrypts it, recomputes the MAC and compares it with the received tag.
- Plaintext is buffered internally and released downstream only when the frame authenticates; a failing frame is dropped whole.
- Sits between the link-side byte source and the consumer of plaintext.

Parameters:
- N, 8, data/key/MAC width in bits
- FRAME_LEN, 4, plaintext words per frame (>=1); each frame on the wire is FRAME_LEN cipher words followed by 1 tag word
- CW, $clog2(FRAME_LEN+1), counter width (derived)

Ports:
- clock  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous active-low reset
- key  in  N  shared secret; sampled on the first word of each frame
- in_data  in  N  ciphertext/tag word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a word; a transfer occurs when in_valid && in_ready
- out_data  out  N  plaintext word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready
- out_last  out  1  marks the final plaintext word of a frame
- valid_key  out  1  result of the last completed check (1 = MAC matched)
- auth_fail  out  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=RECV, idx=0, rd=0, mac=0, key_q=0.
  - out_valid=0, out_last=0, out_data=0, valid_key=0, auth_fail=0.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-release discards everything, with no auth_fail.
- in_ready = (state==RECV) && reset_n. out_valid = (state==RELEASE).
- States RECV, CHECK, RELEASE.
- RECV, on each accepted word (idx = word position in frame):
  - idx==0: key_q<=key. That word and the rest of the frame use the sampled key; key changes mid-frame are ignored.
  - idx<FRAME_LEN:
    - P = in_data ^ k ^ idx[N-1:0], where k = key for idx 0 and key_q thereafter.
    - buf[idx]<=P.
    - mac <= rotl1(m) ^ P, where m = key for idx 0 and mac thereafter. rotl1 = 1-bit rotate left, N bits.
    - idx++.
  - idx==FRAME_LEN: tag_q <= in_data ^ key_q, idx<=0, go CHECK.
  - No accepted word: hold.
- CHECK (exactly 1 cycle, in_ready=0):
  - mac==tag_q: valid_key<=1, rd<=0, go RELEASE.
  - Otherwise: valid_key<=0, auth_fail<=1 for one cycle, go RECV. The buffer is discarded; no out_valid is ever raised for that frame.
- RELEASE:
  - out_data=buf[rd]; out_last=(rd==FRAME_LEN-1).
  - On an out transfer: rd++. On the last word: rd<=0, go RECV.
  - out_ready low: out_data and out_last stay stable.
  - in_ready=0 throughout, so input backpressure lasts the whole release.
- Latency: tag accepted at cycle t -> CHECK at t+1 -> out_valid first high at t+2 (match). On mismatch, auth_fail is high during cycle t+2 and in_ready is high again at t+2.
- Back-to-back frames: after the last out transfer at cycle u, in_ready=1 at u+1. Minimum frame period is FRAME_LEN+1 + 1 + FRAME_LEN cycles.
- valid_key holds its value until the next CHECK or reset.
- All arithmetic is modulo 2^N. idx is truncated to N bits in the XOR.
- in_valid while in_ready=0 causes no state change. The source must hold the word until it is accepted.
- FRAME_LEN=1 works: 1 data word + tag; out_last is high on the single output word.

Test Plan (N=8, FRAME_LEN=4, key=8'h5A unless noted):
- Good frame: send 4B,79,6B,1D,DD with out_ready=1 -> out 11,22,33,44 with out_last on 44; valid_key=1; auth_fail never high; first out_valid 2 cycles after tag accept.
- Bad tag: same frame with tag DC -> no out_valid; auth_fail high exactly 1 cycle; valid_key=0; in_ready high again the same cycle. Then resend the good frame -> 11..44 delivered, valid_key=1.
- Backpressure and gaps: good frame with random in_valid gaps and out_ready toggled every cycle -> identical output sequence; out_data stable while out_ready=0; in_ready=0 throughout RELEASE.
- Key change mid-frame: key=5A for word 0, key=00 for words 1..4 -> frame still authenticates and outputs 11,22,33,44, because key_q was sampled at word 0.
- Reset mid-operation: assert reset_n=0 after 2 words, then after 1 released word; release reset -> all outputs at reset values; next good frame delivered correctly with no stale data.
- Back-to-back: two good frames with in_valid continuously high -> 8 plaintext words, out_last on words 4 and 8, no loss or duplication.
